// File: rtl/wb_memtest_master_if.sv
// Wishbone B3 classic-cycle bus between the memory-test initiator and the DDR2 slave.
// Signal names follow the initiator's point of view.
interface wb_memtest_master_if;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
        input  wb_dat_i, wb_ack_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
        output wb_dat_i, wb_ack_i
    );
endinterface

// File: rtl/wb_memtest_master.sv
// Wishbone memory tester: writes an address-derived pattern over a word range, reads it back and compares.
// Optional MEMTEST_STOP_ON_ERR_EN ends the test on the first read mismatch.
module wb_memtest_master #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned WORDS     = 1024,
    parameter int unsigned TIMEOUT   = 4096
) (
    input  logic                   wb_clk_i,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [31:0]            seed,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic                   timeout,
    output logic [15:0]            err_count,
    output logic [31:0]            first_err_addr,
    wb_memtest_master_if.master    wb
);

    typedef enum logic [2:0] {IDLE, WR, WGAP, RD, RGAP, FIN} state_t;

    localparam logic [31:0] BASE_W   = {BASE_ADDR[31:2], 2'b00};
    localparam logic [23:0] LAST_IDX = 24'(WORDS - 1);
    localparam int          TW       = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT - 1);

    state_t        state;
    logic [23:0]   idx;
    logic [TW-1:0] tmo;
    logic [31:0]   seed_q;
    logic [31:0]   cur_adr;
    logic          rd_bad;

    function automatic logic [31:0] pat(input logic [15:0] w, input logic [31:0] s);
        return {w, ~w} ^ s;
    endfunction

    assign cur_adr = BASE_W + {6'd0, idx, 2'b00};
    // Compare against the registered address: it holds the word being acked.
    assign rd_bad  = (wb.wb_dat_i != pat(wb.wb_adr_o[17:2], seed_q));

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            idx            <= '0;
            tmo            <= '0;
            seed_q         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            wb.wb_cyc_o    <= 1'b0;
            wb.wb_stb_o    <= 1'b0;
            wb.wb_we_o     <= 1'b0;
            wb.wb_sel_o    <= '0;
            wb.wb_adr_o    <= '0;
            wb.wb_dat_o    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        seed_q         <= seed;
                        idx            <= '0;
                        err_count      <= '0;
                        first_err_addr <= '0;
                        timeout        <= 1'b0;
                        pass           <= 1'b0;
                        busy           <= 1'b1;
                        state          <= WR;
                    end
                end

                // First cycle in WR/RD is a setup cycle with the bus still idle,
                // which guarantees two strobe-low cycles between accesses.
                WR, RD: begin
                    if (!wb.wb_stb_o) begin
                        wb.wb_cyc_o <= 1'b1;
                        wb.wb_stb_o <= 1'b1;
                        wb.wb_we_o  <= (state == WR);
                        wb.wb_sel_o <= 4'hF;
                        wb.wb_adr_o <= cur_adr;
                        wb.wb_dat_o <= (state == WR) ? pat(cur_adr[17:2], seed_q) : 32'h0;
                        tmo         <= '0;
                    end else if (wb.wb_ack_i || tmo == TMO_MAX) begin
                        wb.wb_cyc_o <= 1'b0;
                        wb.wb_stb_o <= 1'b0;
                        wb.wb_we_o  <= 1'b0;
                        wb.wb_sel_o <= '0;
                        wb.wb_adr_o <= '0;
                        wb.wb_dat_o <= '0;
                        if (!wb.wb_ack_i) begin
                            timeout <= 1'b1;
                            state   <= FIN;
                        end else if (state == WR) begin
                            state <= WGAP;
                        end else begin
                            if (rd_bad) begin
                                if (err_count != 16'hFFFF)
                                    err_count <= err_count + 16'd1;
                                if (err_count == 16'd0)
                                    first_err_addr <= wb.wb_adr_o;
                            end
`ifdef MEMTEST_STOP_ON_ERR_EN
                            state <= rd_bad ? FIN : RGAP;
`else
                            state <= RGAP;
`endif
                        end
                    end else begin
                        tmo <= tmo + TW'(1);
                    end
                end

                WGAP: begin
                    if (idx == LAST_IDX) begin
                        idx   <= '0;
                        state <= RD;
                    end else begin
                        idx   <= idx + 24'd1;
                        state <= WR;
                    end
                end

                RGAP: begin
                    if (idx == LAST_IDX) begin
                        state <= FIN;
                    end else begin
                        idx   <= idx + 24'd1;
                        state <= RD;
                    end
                end

                FIN: begin
                    pass  <= (err_count == 16'd0) && !timeout;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_memtest_master.sv
// Directed bench for wb_memtest_master against a 3-cycle-ack memory slave with fault injection.
module tb_wb_memtest_master;

    localparam logic [31:0] BASE  = 32'h0000_0100;
    localparam int          WORDS = 4;
    localparam int          TMO   = 16;
    localparam logic [31:0] NONE  = 32'hFFFF_FFF0;

    logic        wb_clk_i = 1'b0;
    logic        rst_n    = 1'b0;
    logic        start    = 1'b0;
    logic [31:0] seed     = '0;
    logic        busy, done, pass, timeout;
    logic [15:0] err_count;
    logic [31:0] first_err_addr;

    always #5 wb_clk_i = ~wb_clk_i;

    wb_memtest_master_if wb ();

    wb_memtest_master #(.BASE_ADDR(BASE), .WORDS(WORDS), .TIMEOUT(TMO)) u_dut (
        .wb_clk_i       (wb_clk_i),
        .rst_n          (rst_n),
        .start          (start),
        .seed           (seed),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .timeout        (timeout),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .wb             (wb.master)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Slave: ack in the third strobe cycle; optional hang on one write, bit-0 flip on one read.
    logic [31:0] mem [16];
    logic        s_ack;
    logic [1:0]  s_cnt;
    logic [31:0] s_dat;
    logic [31:0] hang_adr = NONE;
    logic [31:0] bad_adr  = NONE;

    assign wb.wb_ack_i = s_ack;
    assign wb.wb_dat_i = s_dat;

    always @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            s_ack <= 1'b0;
            s_cnt <= '0;
            s_dat <= '0;
        end else if (wb.wb_cyc_o && wb.wb_stb_o && !s_ack &&
                     !(wb.wb_we_o && wb.wb_adr_o == hang_adr)) begin
            if (s_cnt == 2'd1) begin
                s_ack <= 1'b1;
                s_cnt <= '0;
                if (wb.wb_we_o) mem[wb.wb_adr_o[5:2]] <= wb.wb_dat_o;
                else s_dat <= mem[wb.wb_adr_o[5:2]] ^ ((wb.wb_adr_o == bad_adr) ? 32'h1 : 32'h0);
            end else begin
                s_cnt <= s_cnt + 2'd1;
            end
        end else begin
            s_ack <= 1'b0;
            s_cnt <= '0;
        end
    end

    // Bus monitor, sampled mid-cycle.
    int cyc_n = 0;
    always @(posedge wb_clk_i) cyc_n <= cyc_n + 1;

    logic        clr_mon = 1'b0;
    int          n_wr, n_rd, n_done, viol, stb_hi, max_hi, done_cyc;
    logic [31:0] wd0, wa0, wdl;
    logic [3:0]  sel0;
    logic        prev_stb, prev_ack;

    always @(negedge wb_clk_i) begin
        if (clr_mon) begin
            n_wr <= 0; n_rd <= 0; n_done <= 0; viol <= 0; stb_hi <= 0; max_hi <= 0;
            done_cyc <= 0; wd0 <= '0; wa0 <= '0; wdl <= '0; sel0 <= '0;
            prev_stb <= 1'b0; prev_ack <= 1'b0;
        end else begin
            if (wb.wb_ack_i && wb.wb_stb_o && wb.wb_we_o) begin
                n_wr <= n_wr + 1;
                wdl  <= wb.wb_dat_o;
                if (n_wr == 0) begin
                    wd0  <= wb.wb_dat_o;
                    wa0  <= wb.wb_adr_o;
                    sel0 <= wb.wb_sel_o;
                end
            end
            if (wb.wb_stb_o && !prev_stb && !wb.wb_we_o) n_rd <= n_rd + 1;
            if (prev_ack && wb.wb_stb_o) viol <= viol + 1;
            stb_hi <= wb.wb_stb_o ? stb_hi + 1 : 0;
            if (wb.wb_stb_o && stb_hi + 1 > max_hi) max_hi <= stb_hi + 1;
            if (done) begin
                n_done   <= n_done + 1;
                done_cyc <= cyc_n;
            end
            prev_stb <= wb.wb_stb_o;
            prev_ack <= wb.wb_ack_i && wb.wb_stb_o;
        end
    end

    int t0;

    task automatic launch(input logic [31:0] s);
        @(posedge wb_clk_i); #1 clr_mon = 1'b1;
        @(posedge wb_clk_i); #1 clr_mon = 1'b0;
        start = 1'b1;
        seed  = s;
        t0    = cyc_n;
        @(posedge wb_clk_i); #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit found = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(posedge wb_clk_i); #1;
            if (done) begin
                found = 1'b1;
                break;
            end
        end
        chk({tag, "_done_seen"}, 32'(found), 32'd1);
        repeat (6) @(negedge wb_clk_i);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge wb_clk_i);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_tmo",  32'(timeout), 32'd0);
        chk("rst_err",  32'(err_count), 32'd0);
        chk("rst_ferr", first_err_addr, 32'd0);
        chk("rst_cyc",  32'(wb.wb_cyc_o), 32'd0);
        chk("rst_stb",  32'(wb.wb_stb_o), 32'd0);
        rst_n = 1'b1;

        // Clean run, seed 0, with a stray start pulse while busy
        launch(32'h0);
        chk("t1_busy", 32'(busy), 32'd1);
        repeat (10) @(posedge wb_clk_i);
        #1 start = 1'b1;
        @(posedge wb_clk_i); #1 start = 1'b0;
        wait_done("t1");
        chk("t1_pass",   32'(pass), 32'd1);
        chk("t1_err",    32'(err_count), 32'd0);
        chk("t1_ferr",   first_err_addr, 32'd0);
        chk("t1_tmo",    32'(timeout), 32'd0);
        chk("t1_nwr",    32'(n_wr), 32'd4);
        chk("t1_nrd",    32'(n_rd), 32'd4);
        chk("t1_wa0",    wa0, 32'h0000_0100);
        chk("t1_wd0",    wd0, 32'h0040_FFBF);
        chk("t1_wdl",    wdl, 32'h0043_FFBC);
        chk("t1_sel",    32'(sel0), 32'hF);
        chk("t1_cycles", 32'(done_cyc - t0), 32'd42);
        chk("t1_ndone",  32'(n_done), 32'd1);
        chk("t1_viol",   32'(viol), 32'd0);
        chk("t1_busy_end", 32'(busy), 32'd0);

        // Read corruption at 0x108
        bad_adr = 32'h0000_0108;
        launch(32'h1234_5678);
        wait_done("t2");
        chk("t2_err",  32'(err_count), 32'd1);
        chk("t2_ferr", first_err_addr, 32'h0000_0108);
        chk("t2_pass", 32'(pass), 32'd0);
        chk("t2_wd0",  wd0, 32'h1274_A9C7);
`ifdef MEMTEST_STOP_ON_ERR_EN
        chk("t2_nrd",  32'(n_rd), 32'd3);
`else
        chk("t2_nrd",  32'(n_rd), 32'd4);
`endif
        bad_adr = NONE;

        // Second write never acked
        hang_adr = 32'h0000_0104;
        launch(32'h0);
        wait_done("t3");
        chk("t3_tmo",   32'(timeout), 32'd1);
        chk("t3_pass",  32'(pass), 32'd0);
        chk("t3_nwr",   32'(n_wr), 32'd1);
        chk("t3_nrd",   32'(n_rd), 32'd0);
        chk("t3_stbhi", 32'(max_hi), 32'd16);
        chk("t3_ndone", 32'(n_done), 32'd1);
        chk("t3_stb",   32'(wb.wb_stb_o), 32'd0);
        hang_adr = NONE;

        // All-ones seed
        launch(32'hFFFF_FFFF);
        wait_done("t4");
        chk("t4_wd0",  wd0, 32'hFFBF_0040);
        chk("t4_pass", 32'(pass), 32'd1);
        chk("t4_tmo",  32'(timeout), 32'd0);

        // Reset in the middle of a read
        launch(32'h0);
        begin
            bit hit = 1'b0;
            for (int k = 0; k < 200; k++) begin
                @(negedge wb_clk_i);
                if (wb.wb_stb_o && !wb.wb_we_o) begin
                    hit = 1'b1;
                    break;
                end
            end
            chk("t5_rd_seen", 32'(hit), 32'd1);
        end
        rst_n = 1'b0;
        #1;
        chk("t5_cyc",  32'(wb.wb_cyc_o), 32'd0);
        chk("t5_stb",  32'(wb.wb_stb_o), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge wb_clk_i);
        rst_n = 1'b1;
        repeat (2) @(negedge wb_clk_i);
        chk("t5_adr",  wb.wb_adr_o, 32'd0);
        chk("t5_dat",  wb.wb_dat_o, 32'd0);
        chk("t5_err",  32'(err_count), 32'd0);
        chk("t5_pass", 32'(pass), 32'd0);

        // Fresh run after reset
        launch(32'hA5A5_0F0F);
        wait_done("t6");
        chk("t6_pass",   32'(pass), 32'd1);
        chk("t6_cycles", 32'(done_cyc - t0), 32'd42);
        chk("t6_ndone",  32'(n_done), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
